// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch port: the fetch stage raises req/addr, memory returns ack/rdata.
interface if_fetch_stage_if;
   localparam int unsigned XLEN = 32;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// CPU instruction fetch stage: owns the PC, fetches over req/ack into the IR and
// resolves branch, jump and jump-register targets when the IR is consumed.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int unsigned XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   if_fetch_stage_if.master imem,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  imm_ext,
   input  logic             jump,
   input  logic             jr,
   input  logic [XLEN-1:0]  jr_target,
   output logic             ir_valid,
   output logic [XLEN-1:0]  ir,
   output logic [15:0]      imm16,
   output logic [XLEN-1:0]  ir_pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic [XLEN-1:0]  instret
);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_ir;
   logic [XLEN-1:0] r_ir_pc;
   logic            r_ir_valid;
   logic [XLEN-1:0] r_instret;

   logic            w_fetch_done;
   logic            w_consume;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_br_target;
   logic [XLEN-1:0] w_next_pc;
   logic            w_unused_bits;

   assign w_fetch_done = (r_state == S_FETCH) && imem.imem_ack;
   assign w_consume    = (r_state == S_ISSUE) && !stall;

   // State register; reset forces BOOT so imem_req drops without waiting for an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_BOOT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_FETCH;
         S_FETCH: if (imem.imem_ack) w_state_nxt = S_ISSUE;
         S_ISSUE: if (!stall)        w_state_nxt = S_FETCH;
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // Target resolution, priority jr > jump > branch > sequential.
   assign w_pc_plus4  = r_ir_pc + XLEN'(4);
   assign w_br_target = w_pc_plus4 + {imm_ext[29:0], 2'b00};

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (jr)            w_next_pc = {jr_target[31:2], 2'b00};
      else if (jump)     w_next_pc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
      else if (br_taken) w_next_pc = w_br_target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_instret  <= '0;
      end else if (w_fetch_done) begin
         r_ir       <= imem.imem_rdata;
         r_ir_pc    <= r_pc;
         r_ir_valid <= 1'b1;
      end else if (w_consume) begin
         r_pc       <= w_next_pc;
         r_ir_valid <= 1'b0;
         r_instret  <= r_instret + XLEN'(1);
      end
   end

   assign imem.imem_req  = (r_state == S_FETCH);
   assign imem.imem_addr = r_pc;

   assign ir_valid = r_ir_valid;
   assign ir       = r_ir;
   assign imm16    = r_ir[15:0];
   assign ir_pc    = r_ir_pc;
   assign pc_plus4 = w_pc_plus4;
   assign instret  = r_instret;

   // Offset bits shifted out and the forced-zero jr target bits are intentionally dropped.
   assign w_unused_bits = &{1'b0, imm_ext[31:30], jr_target[1:0]};

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [31:0] imm_ext;
   logic        jump;
   logic        jr;
   logic [31:0] jr_target;
   logic        ir_valid;
   logic [31:0] ir;
   logic [15:0] imm16;
   logic [31:0] ir_pc;
   logic [31:0] pc_plus4;
   logic [31:0] instret;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_instret;
   logic [31:0] held_ir;

   if_fetch_stage_if u_if ();

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .imem      (u_if),
      .stall     (stall),
      .br_taken  (br_taken),
      .imm_ext   (imm_ext),
      .jump      (jump),
      .jr        (jr),
      .jr_target (jr_target),
      .ir_valid  (ir_valid),
      .ir        (ir),
      .imm16     (imm16),
      .ir_pc     (ir_pc),
      .pc_plus4  (pc_plus4),
      .instret   (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge in FETCH; acks after 'waits' idle cycles, ends at a negedge in ISSUE.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
      for (int i = 0; i < waits; i++) begin
         check("wait_req", 32'(u_if.imem_req), 32'd1);
         check("wait_addr", u_if.imem_addr, addr);
         @(negedge clk);
      end
      check("fetch_req", 32'(u_if.imem_req), 32'd1);
      check("fetch_addr", u_if.imem_addr, addr);
      u_if.imem_ack   = 1'b1;
      u_if.imem_rdata = word;
      @(negedge clk);
      u_if.imem_ack   = 1'b0;
      check("ir_valid", 32'(ir_valid), 32'd1);
      check("ir", ir, word);
      check("ir_pc", ir_pc, addr);
   endtask

   // Entered at a negedge in ISSUE; consumes on the next edge and checks the new fetch address.
   task automatic consume(input string tag, input logic b, input logic j, input logic r,
                          input logic [31:0] jrt, input logic [31:0] imm,
                          input logic [31:0] exp_addr);
      stall     = 1'b0;
      br_taken  = b;
      jump      = j;
      jr        = r;
      jr_target = jrt;
      imm_ext   = imm;
      @(negedge clk);
      br_taken  = 1'b0;
      jump      = 1'b0;
      jr        = 1'b0;
      jr_target = 32'h0;
      imm_ext   = 32'h0;
      exp_instret = exp_instret + 32'd1;
      check({tag, "_req"}, 32'(u_if.imem_req), 32'd1);
      check({tag, "_addr"}, u_if.imem_addr, exp_addr);
      check({tag, "_instret"}, instret, exp_instret);
      check({tag, "_valid"}, 32'(ir_valid), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_instret = 32'd0;
      rst = 1'b1;
      stall = 1'b0;
      br_taken = 1'b0;
      imm_ext = 32'h0;
      jump = 1'b0;
      jr = 1'b0;
      jr_target = 32'h0;
      u_if.imem_ack = 1'b0;
      u_if.imem_rdata = 32'h0;

      // Reset hold and release
      repeat (2) @(negedge clk);
      check("rst_req", 32'(u_if.imem_req), 32'd0);
      check("rst_valid", 32'(ir_valid), 32'd0);
      check("rst_instret", instret, 32'd0);
      rst = 1'b0;
      #1;
      check("boot_req", 32'(u_if.imem_req), 32'd0);
      @(negedge clk);
      check("first_req", 32'(u_if.imem_req), 32'd1);
      check("first_addr", u_if.imem_addr, 32'h0);

      // Zero-wait fetch followed by a sequential consume
      u_if.imem_ack   = 1'b1;
      u_if.imem_rdata = 32'h2008_0005;
      @(negedge clk);
      u_if.imem_ack = 1'b0;
      check("zw_valid", 32'(ir_valid), 32'd1);
      check("zw_imm16", 32'(imm16), 32'h5);
      check("zw_ir_pc", ir_pc, 32'h0);
      check("zw_pc_plus4", pc_plus4, 32'h4);
      check("zw_issue_req", 32'(u_if.imem_req), 32'd0);
      @(negedge clk);
      exp_instret = 32'd1;
      check("zw_next_req", 32'(u_if.imem_req), 32'd1);
      check("zw_next_addr", u_if.imem_addr, 32'h4);
      check("zw_instret", instret, exp_instret);

      // Walk forward to 0x10, then a backward taken branch
      fetch(32'h4, 32'h0000_0000, 0);
      consume("seq4", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      fetch(32'h8, 32'h0000_0000, 1);
      consume("seq8", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
      fetch(32'hC, 32'h0000_0000, 0);
      consume("seqC", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
      fetch(32'h10, 32'h1000_FFFE, 0);
      consume("branch", 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'hC);

      // Jump beats branch; jr beats jump and clears low bits
      fetch(32'hC, 32'h0000_0000, 0);
      consume("jr_setup", 1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'h0, 32'h1000_0020);
      fetch(32'h1000_0020, 32'h0800_0040, 0);
      consume("jump", 1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 32'h1000_0100);
      fetch(32'h1000_0100, 32'h0800_0040, 0);
      consume("jr", 1'b1, 1'b1, 1'b1, 32'h0000_0203, 32'h10, 32'h200);

      // Stall held through waits and ISSUE, then exactly one consume
      stall = 1'b1;
      fetch(32'h200, 32'hABCD_1234, 3);
      held_ir = ir;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_ir", ir, held_ir);
         check("stall_req", 32'(u_if.imem_req), 32'd0);
         check("stall_instret", instret, exp_instret);
         check("stall_valid", 32'(ir_valid), 32'd1);
      end
      consume("unstall", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h204);
      fetch(32'h204, 32'h0000_0000, 3);

      // PC wraps to zero
      consume("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      consume("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      fetch(32'h0, 32'h0000_0000, 0);
      consume("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

      // Reset while a fetch is outstanding; an ack during reset is dropped
      rst = 1'b1;
      #1;
      check("midrst_req", 32'(u_if.imem_req), 32'd0);
      u_if.imem_ack   = 1'b1;
      u_if.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("midrst_valid", 32'(ir_valid), 32'd0);
      check("midrst_ir", ir, 32'h0);
      check("midrst_instret", instret, 32'h0);
      u_if.imem_ack = 1'b0;
      rst = 1'b0;
      exp_instret = 32'd0;
      #1;
      check("rerel_req", 32'(u_if.imem_req), 32'd0);
      @(negedge clk);
      fetch(32'h0, 32'h2008_0005, 1);
      check("refetch_imm16", 32'(imm16), 32'h5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
